// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module   : cdb_arbiter (with package cdb_pkg)
// Purpose  : Round-robin arbiter for the common data bus. It grants one result
//            per cycle and registers it onto the broadcast outputs.
// Options  : CDB_PERF_CNT_EN adds saturating grant and conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_pkg;
    typedef enum logic [3:0] {
        FU_0,  FU_1,  FU_2,  FU_3,  FU_4,  FU_5,  FU_6,  FU_7,
        FU_8,  FU_9,  FU_10, FU_11, FU_12, FU_13, FU_14, FU_15
    } e_functional_unit;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_UNITS  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush_i,
    input  logic [NUM_UNITS-1:0]                  req_valid_i,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  req_value_i,
    output logic [NUM_UNITS-1:0]                  req_ready_o,
    output logic                                  bcast_valid_o,
    output logic [DATA_WIDTH-1:0]                 bcast_value_o,
    output e_functional_unit                      bcast_rs_o
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [NUM_UNITS-1:0][CNT_WIDTH-1:0]   grant_cnt_o,
    output logic [CNT_WIDTH-1:0]                  conflict_cnt_o
`endif
);

    localparam int PTR_W = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_idx;
    logic [PTR_W-1:0]     w_next_ptr;
    logic                 w_any;
    logic                 w_fire;
    logic [NUM_UNITS-1:0] w_grant;
    int                   w_u;

    // Scan from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_u   = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_u = (int'(r_ptr) + k) % NUM_UNITS;
            if (!w_any && req_valid_i[w_u]) begin
                w_any = 1'b1;
                w_idx = PTR_W'(w_u);
            end
        end
    end

    assign w_fire      = w_any & ~flush_i & ~rst;
    assign w_grant     = w_fire ? (NUM_UNITS'(1) << w_idx) : '0;
    assign req_ready_o = w_grant;
    assign w_next_ptr  = (int'(w_idx) == NUM_UNITS - 1) ? '0 : w_idx + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= '0;
            bcast_valid_o <= 1'b0;
            bcast_value_o <= '0;
            bcast_rs_o    <= FU_0;
        end else begin
            bcast_valid_o <= w_fire;
            if (w_fire) begin
                r_ptr         <= w_next_ptr;
                bcast_value_o <= req_value_i[w_idx];
                bcast_rs_o    <= e_functional_unit'(4'(w_idx));
            end
        end
    end

`ifdef CDB_PERF_CNT_EN
    logic w_conflict;
    assign w_conflict = ~flush_i & ($countones(req_valid_i) > 1);

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_grant_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                grant_cnt_o[g] <= '0;
            end else if (w_grant[g] && (grant_cnt_o[g] != '1)) begin
                grant_cnt_o[g] <= grant_cnt_o[g] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_o <= '0;
        end else if (w_conflict && (conflict_cnt_o != '1)) begin
            conflict_cnt_o <= conflict_cnt_o + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Directed self-checking bench for cdb_arbiter (4 units, 64-bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int C_DW  = 64;
    localparam int C_NU  = 4;
    localparam int C_CW  = 4;

    logic                       clk;
    logic                       rst;
    logic                       flush_i;
    logic [C_NU-1:0]            req_valid_i;
    logic [C_NU-1:0][C_DW-1:0]  req_value_i;
    logic [C_NU-1:0]            req_ready_o;
    logic                       bcast_valid_o;
    logic [C_DW-1:0]            bcast_value_o;
    e_functional_unit           bcast_rs_o;
`ifdef CDB_PERF_CNT_EN
    logic [C_NU-1:0][C_CW-1:0]  grant_cnt_o;
    logic [C_CW-1:0]            conflict_cnt_o;
`endif

    int n_cmp;
    int n_err;

    cdb_arbiter #(
        .DATA_WIDTH (C_DW),
        .NUM_UNITS  (C_NU),
        .CNT_WIDTH  (C_CW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_value_i    (req_value_i),
        .req_ready_o    (req_ready_o),
        .bcast_valid_o  (bcast_valid_o),
        .bcast_value_o  (bcast_value_o),
        .bcast_rs_o     (bcast_rs_o)
`ifdef CDB_PERF_CNT_EN
        ,
        .grant_cnt_o    (grant_cnt_o),
        .conflict_cnt_o (conflict_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = '0;
        for (int i = 0; i < C_NU; i++) req_value_i[i] = 64'h100 + 64'(i);

        // Reset cycle: no grant even with all units requesting
        req_valid_i = 4'b1111;
        #1 chk("rst_ready", 64'(req_ready_o), 64'h0);
        tick();
        chk("rst_bvalid", 64'(bcast_valid_o), 64'h0);
        chk("rst_bvalue", bcast_value_o, 64'h0);
        chk("rst_brs", 64'(bcast_rs_o), 64'h0);
        rst = 1'b0;
        req_valid_i = '0;

        // Single request from unit 2
        req_value_i[2] = 64'hDEAD;
        req_valid_i = 4'b0100;
        #1 chk("single_ready", 64'(req_ready_o), 64'h4);
        tick();
        req_valid_i = '0;
        chk("single_bvalid", 64'(bcast_valid_o), 64'h1);
        chk("single_bvalue", bcast_value_o, 64'hDEAD);
        chk("single_brs", 64'(bcast_rs_o), 64'h2);
        tick();
        chk("single_idle_bvalid", 64'(bcast_valid_o), 64'h0);
        chk("single_hold_value", bcast_value_o, 64'hDEAD);
        chk("single_hold_rs", 64'(bcast_rs_o), 64'h2);
        req_value_i[2] = 64'h102;

        // All units requesting from ptr=0: order 0,1,2,3,0 without bubbles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid_i = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1 chk("rr_ready", 64'(req_ready_o), 64'(1) << (c % 4));
            tick();
            chk("rr_bvalid", 64'(bcast_valid_o), 64'h1);
            chk("rr_bvalue", bcast_value_o, 64'h100 + 64'(c % 4));
            chk("rr_brs", 64'(bcast_rs_o), 64'(c % 4));
        end

        // Move ptr to 2, then units 1 and 3 compete
        req_valid_i = 4'b0010;
        #1 chk("ptr2_ready", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = 4'b1010;
        #1 chk("pair_ready_first", 64'(req_ready_o), 64'h8);
        tick();
        chk("pair_brs_first", 64'(bcast_rs_o), 64'h3);
        req_valid_i = 4'b0010;
        #1 chk("pair_ready_second", 64'(req_ready_o), 64'h2);
        tick();
        chk("pair_brs_second", 64'(bcast_rs_o), 64'h1);
        chk("pair_bvalue_second", bcast_value_o, 64'h101);
`ifdef CDB_PERF_CNT_EN
        chk("conflict_cnt", 64'(conflict_cnt_o), 64'h6);
        chk("grant_cnt0", 64'(grant_cnt_o[0]), 64'h2);
`endif
        req_valid_i = 4'b1111;
        #1 chk("ptr_after_pair", 64'(req_ready_o), 64'h4);

        // Bring ptr to 0, then flush while units 0 and 1 request
        req_valid_i = 4'b1000;
        tick();
        flush_i = 1'b1;
        req_valid_i = 4'b0011;
        #1 chk("flush_ready", 64'(req_ready_o), 64'h0);
        tick();
        chk("flush_bvalid", 64'(bcast_valid_o), 64'h0);
        chk("flush_hold_rs", 64'(bcast_rs_o), 64'h3);
        flush_i = 1'b0;
        #1 chk("post_flush_ready", 64'(req_ready_o), 64'h1);
        tick();
        chk("post_flush_bvalid", 64'(bcast_valid_o), 64'h1);
        chk("post_flush_brs", 64'(bcast_rs_o), 64'h0);

        // Reset the cycle after a grant to unit 1
        req_valid_i = 4'b0010;
        #1 chk("pre_rst_ready", 64'(req_ready_o), 64'h2);
        tick();
        chk("pre_rst_bvalid", 64'(bcast_valid_o), 64'h1);
        rst = 1'b1;
        #1 chk("mid_rst_ready", 64'(req_ready_o), 64'h0);
        tick();
        chk("mid_rst_bvalid", 64'(bcast_valid_o), 64'h0);
        chk("mid_rst_bvalue", bcast_value_o, 64'h0);
`ifdef CDB_PERF_CNT_EN
        chk("mid_rst_conflict", 64'(conflict_cnt_o), 64'h0);
        chk("mid_rst_grant1", 64'(grant_cnt_o[1]), 64'h0);
`endif
        rst = 1'b0;
        req_valid_i = 4'b1111;
        #1 chk("after_rst_ptr", 64'(req_ready_o), 64'h1);
        req_valid_i = '0;
        tick();
        chk("idle_bvalid", 64'(bcast_valid_o), 64'h0);

`ifdef CDB_PERF_CNT_EN
        // Saturation of a 4-bit grant counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid_i = 4'b0001;
        repeat (20) tick();
        req_valid_i = '0;
        chk("sat_grant0", 64'(grant_cnt_o[0]), 64'hF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
